// File: rtl/heavy_part_sweep_ctrl.sv
// heavy_part_sweep_ctrl: shares one heavy-part bucket RAM between the packet pipeline
// and an epoch sweep that dumps every bucket to the collector and clears it.
module heavy_part_sweep_ctrl #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 96,
    parameter int DEPTH      = 4096,
    parameter int RD_LAT     = 2,
    parameter int DRAIN_MIN  = 4,
    parameter bit SKIP_EMPTY = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     dump_req,
    output logic                     dump_busy,
    output logic                     dump_done,
    output logic                     hold_alf,
    input  logic                     pipe_idle,
    input  logic                     p_rden,
    input  logic [ADDR_W-1:0]        p_rdaddr,
    input  logic                     p_wren,
    input  logic [ADDR_W-1:0]        p_wraddr,
    input  logic [DATA_W-1:0]        p_wrdata,
    output logic [DATA_W-1:0]        p_rdvalue,
    output logic                     ram_rden,
    output logic [ADDR_W-1:0]        ram_rdaddr,
    output logic                     ram_wren,
    output logic [ADDR_W-1:0]        ram_wraddr,
    output logic [DATA_W-1:0]        ram_wrdata,
    input  logic [DATA_W-1:0]        ram_q,
    output logic                     dump_wr,
    output logic [ADDR_W+DATA_W-1:0] dump_data,
    input  logic                     dump_alf,
    output logic                     conflict_err
);
    localparam int CW = $clog2(DRAIN_MIN + 1);
    localparam int SW = ADDR_W + 1;

    typedef enum logic [2:0] {IDLE, DRAIN, SWEEP, FLUSH, DONE} state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     idle_cnt, idle_cnt_nx;
    logic [SW-1:0]     sw_addr, sw_addr_nx;
    logic [RD_LAT-1:0] pv, pv_nx;
    logic [ADDR_W-1:0] pa [RD_LAT];
    logic              sweeping, issue, out_v;
    logic [ADDR_W-1:0] out_a;

    assign sweeping     = state == SWEEP || state == FLUSH;
    assign issue        = state == SWEEP && !dump_alf;
    // Valid bits track reads in flight; the last stage lines up with ram_q.
    assign pv_nx        = (pv << 1) | RD_LAT'(issue);
    assign out_v        = pv[RD_LAT-1];
    assign out_a        = pa[RD_LAT-1];
    assign dump_busy    = state == DRAIN || sweeping;
    assign hold_alf     = dump_busy;
    assign dump_done    = state == DONE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            idle_cnt     <= '0;
            sw_addr      <= '0;
            pv           <= '0;
            conflict_err <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) pa[i] <= '0;
        end else begin
            state    <= state_nx;
            idle_cnt <= idle_cnt_nx;
            sw_addr  <= sw_addr_nx;
            pv       <= pv_nx;
            pa[0]    <= sw_addr[ADDR_W-1:0];
            for (int i = 1; i < RD_LAT; i++) pa[i] <= pa[i-1];
            if (sweeping && (p_rden || p_wren)) conflict_err <= 1'b1;
        end
    end

    always_comb begin
        state_nx    = state;
        idle_cnt_nx = idle_cnt;
        sw_addr_nx  = sw_addr;
        case (state)
            IDLE: begin
                idle_cnt_nx = '0;
                if (dump_req) state_nx = DRAIN;
            end
            DRAIN: begin
                idle_cnt_nx = pipe_idle ? idle_cnt + 1'b1 : '0;
                sw_addr_nx  = '0;
                if (idle_cnt_nx == CW'(DRAIN_MIN)) state_nx = SWEEP;
            end
            SWEEP: begin
                // One extra address bit lets the last issue land on DEPTH instead of wrapping.
                sw_addr_nx = sw_addr + SW'(issue);
                if (sw_addr_nx == SW'(DEPTH)) state_nx = FLUSH;
            end
            FLUSH: if (pv_nx == '0) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ram_rden   = 1'b0;
        ram_rdaddr = '0;
        ram_wren   = 1'b0;
        ram_wraddr = '0;
        ram_wrdata = '0;
        dump_wr    = 1'b0;
        dump_data  = '0;
        p_rdvalue  = reset ? ram_q : '0;
        if (reset && sweeping) begin
            ram_rden   = issue;
            ram_rdaddr = issue ? sw_addr[ADDR_W-1:0] : '0;
            ram_wren   = out_v;
            ram_wraddr = out_v ? out_a : '0;
            dump_wr    = out_v && !(SKIP_EMPTY && ram_q == '0);
            dump_data  = dump_wr ? {out_a, ram_q} : '0;
        end else if (reset) begin
            ram_rden   = p_rden;
            ram_rdaddr = p_rdaddr;
            ram_wren   = p_wren;
            ram_wraddr = p_wraddr;
            ram_wrdata = p_wrdata;
        end
    end
endmodule

// File: tb/tb_heavy_part_sweep_ctrl.sv
// tb_heavy_part_sweep_ctrl: directed bench with a 2-cycle-latency RAM model for
// heavy_part_sweep_ctrl.
module tb_heavy_part_sweep_ctrl;
    localparam int AW = 12;
    localparam int DW = 96;
    localparam int DEPTH = 4096;

    logic clk = 0, reset = 0, dump_req = 0, pipe_idle = 0, p_rden = 0, p_wren = 0, dump_alf = 0;
    logic [AW-1:0] p_rdaddr = '0, p_wraddr = '0;
    logic [DW-1:0] p_wrdata = '0;
    logic dump_busy, dump_done, hold_alf, ram_rden, ram_wren, dump_wr, conflict_err;
    logic [AW-1:0] ram_rdaddr, ram_wraddr;
    logic [DW-1:0] ram_wrdata, p_rdvalue;
    logic [AW+DW-1:0] dump_data;
    bit [DW-1:0] mem [DEPTH];
    bit [DW-1:0] r1, ram_q;
    int total = 0, bad = 0, cyc = 0;
    bit mon_en = 0;
    logic [0:7] pat = 8'b11101111;
    logic [AW+DW-1:0] dq[$];
    int dt[$], rq[$], rt[$];
    logic [AW+DW-1:0] exp4 [4];

    heavy_part_sweep_ctrl dut (
        .clk(clk), .reset(reset), .dump_req(dump_req), .dump_busy(dump_busy),
        .dump_done(dump_done), .hold_alf(hold_alf), .pipe_idle(pipe_idle),
        .p_rden(p_rden), .p_rdaddr(p_rdaddr), .p_wren(p_wren), .p_wraddr(p_wraddr),
        .p_wrdata(p_wrdata), .p_rdvalue(p_rdvalue), .ram_rden(ram_rden),
        .ram_rdaddr(ram_rdaddr), .ram_wren(ram_wren), .ram_wraddr(ram_wraddr),
        .ram_wrdata(ram_wrdata), .ram_q(ram_q), .dump_wr(dump_wr), .dump_data(dump_data),
        .dump_alf(dump_alf), .conflict_err(conflict_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_wren) mem[ram_wraddr] <= ram_wrdata;
        if (ram_rden) r1 <= mem[ram_rdaddr];
        ram_q <= r1;
    end

    always @(negedge clk) begin
        #3;
        if (dump_wr) begin dq.push_back(dump_data); dt.push_back(cyc); end
        if (mon_en && ram_rden) begin rq.push_back(int'(ram_rdaddr)); rt.push_back(cyc); end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic pwrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk); p_wren = 1; p_wraddr = a; p_wrdata = d;
        @(negedge clk); p_wren = 0; p_wraddr = '0; p_wrdata = '0;
    endtask

    task automatic clearq();
        dq.delete(); dt.delete(); rq.delete(); rt.delete();
    endtask

    task automatic start(output int t);
        @(negedge clk); dump_req = 1; t = cyc;
        @(negedge clk); dump_req = 0;
    endtask

    task automatic wait_done(input int lim, output int dc);
        dc = -1;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk); #1;
            if (dump_done) begin dc = cyc; break; end
        end
    endtask

    function automatic int seq_err();
        int e = (rq.size() != DEPTH) ? 1 : 0;
        for (int i = 0; i < rq.size(); i++) if (rq[i] != i) e++;
        return e;
    endfunction

    initial begin
        int t, dc, e;
        bit found;
        repeat (3) @(negedge clk);
        p_rden = 1; p_wren = 1; p_rdaddr = 12'h123; p_wraddr = 12'h456; p_wrdata = 96'h1;
        #1;
        chk("rst_ctl", {dump_busy, dump_done, hold_alf, dump_wr, conflict_err, ram_rden, ram_wren}, 0);
        chk("rst_addr", {ram_rdaddr, ram_wraddr}, 0);
        chk("rst_wrdata", ram_wrdata, 0);
        chk("rst_dump", dump_data, 0);
        @(negedge clk); p_rden = 0; p_wren = 0; p_rdaddr = '0; p_wraddr = '0; p_wrdata = '0;
        @(negedge clk); reset = 1;

        @(negedge clk); p_wren = 1; p_wraddr = 12'h005; p_wrdata = 96'hABC; #1;
        chk("pt_wr", {ram_wren, ram_wraddr, ram_wrdata}, {1'b1, 12'h005, 96'hABC});
        @(negedge clk); p_wren = 0; p_rden = 1; p_rdaddr = 12'h005; #1;
        chk("pt_rd", {ram_rden, ram_rdaddr, ram_wren}, {1'b1, 12'h005, 1'b0});
        @(negedge clk); p_rden = 0; p_rdaddr = '0; #1;
        chk("pt_lat1", p_rdvalue, 0);
        @(negedge clk); #1;
        chk("pt_lat2", p_rdvalue, 96'hABC);
        chk("pt_idle", {dump_busy, hold_alf}, 0);

        pwrite(12'h005, 0); pwrite(12'h000, 1); pwrite(12'h7FF, 2); pwrite(12'hFFF, 3);
        pipe_idle = 1; mon_en = 1; clearq();
        start(t); #1;
        chk("req_busy", {dump_busy, hold_alf}, 2'b11);
        wait_done(5000, dc);
        chk("sw_done_lat", dc - t, 4103);
        chk("sw_done_flags", {dump_busy, hold_alf}, 0);
        chk("sw_n", dq.size(), 3);
        chk("sw_w0", dq[0], {12'h000, 96'd1});
        chk("sw_w1", dq[1], {12'h7FF, 96'd2});
        chk("sw_w2", dq[2], {12'hFFF, 96'd3});
        chk("sw_last_wr", dt[2] - t, 4102);
        chk("sw_first_rd", rt[0] - t, 5);
        chk("sw_seq", seq_err(), 0);
        chk("sw_contig", rt[DEPTH-1] - rt[0], DEPTH - 1);
        @(negedge clk); #1;
        chk("done_pulse", dump_done, 0);
        e = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] != 0) e++;
        chk("ram_clear", e, 0);

        pipe_idle = 0;
        pwrite(12'h003, 5); pwrite(12'h400, 7); pwrite(12'h401, 9); pwrite(12'hABC, 1);
        exp4[0] = {12'h003, 96'd5}; exp4[1] = {12'h400, 96'd7};
        exp4[2] = {12'h401, 96'd9}; exp4[3] = {12'hABC, 96'd1};
        clearq();
        @(negedge clk); dump_req = 1; t = cyc;
        for (int i = 0; i < 8; i++) begin @(negedge clk); dump_req = 0; pipe_idle = pat[i]; end
        repeat (1000) @(negedge clk);
        dump_alf = 1; #1;
        chk("bp_no_read", ram_rden, 0);
        repeat (100) @(negedge clk);
        dump_alf = 0;
        wait_done(6000, dc);
        chk("dr_first_rd", rt[0] - t, 9);
        chk("bp_seq", seq_err(), 0);
        chk("bp_done_lat", dc - t, 4207);
        chk("bp_n", dq.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("bp_w%0d", i), dq[i], exp4[i]);

        pwrite(12'hF00, 96'h77); clearq();
        start(t);
        repeat (20) @(negedge clk);
        p_wren = 1; p_wraddr = 12'hF00; p_wrdata = 96'h55; dump_req = 1; #1;
        chk("cf_blocked", {ram_wraddr == 12'hF00, ram_wrdata}, 0);
        @(negedge clk); p_wren = 0; p_wraddr = '0; p_wrdata = '0; dump_req = 0; #1;
        chk("cf_err", conflict_err, 1);
        wait_done(5000, dc);
        chk("cf_done_lat", dc - t, 4103);
        chk("cf_n", dq.size(), 1);
        chk("cf_word", dq[0], {12'hF00, 96'h77});
        repeat (30) @(negedge clk); #1;
        chk("cf_sticky", conflict_err, 1);
        chk("no_resweep", {rq.size(), dump_busy}, {DEPTH, 1'b0});

        clearq();
        start(t);
        found = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            if (ram_rden && ram_rdaddr == 12'h100) begin found = 1; break; end
        end
        chk("ar_reach", found, 1);
        reset = 0; #1;
        chk("ar_ctl", {dump_busy, hold_alf, dump_wr, ram_rden, ram_wren, conflict_err, dump_done}, 0);
        chk("ar_addr", {ram_rdaddr, ram_wraddr, dump_data}, 0);
        @(negedge clk); reset = 1;
        @(negedge clk); #1;
        chk("ar_idle", {dump_busy, hold_alf, conflict_err}, 0);
        pwrite(12'h050, 4); pwrite(12'h200, 6); clearq();
        start(t);
        wait_done(5000, dc);
        chk("rs_done_lat", dc - t, 4103);
        chk("rs_seq", seq_err(), 0);
        chk("rs_n", dq.size(), 2);
        chk("rs_w0", dq[0], {12'h050, 96'd4});
        chk("rs_w1", dq[1], {12'h200, 96'd6});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/heavy_part_sweep_ctrl.md
# heavy_part_sweep_ctrl

Dump-and-clear controller for one heavy-part bucket RAM (96-bit × 4096). It sits between the heavy-part read/compare stages and the RAM's ports and arbitrates between the two users. In normal operation it forwards packet-pipeline accesses to the RAM unchanged. On an epoch request it stalls the pipeline, drains in-flight work, then streams every bucket out to the collector while writing the bucket back to zero.

## Interface
- ADDR_W, 12, bucket address width
- DATA_W, 96, bucket width (key + counters)
- DEPTH, 4096, buckets swept, 2^ADDR_W
- RD_LAT, 2, RAM read latency, rden to q valid, in cycles
- DRAIN_MIN, 4, consecutive pipe_idle cycles required before sweeping
- SKIP_EMPTY, 1, 1 = suppress dump_wr for all-zero buckets

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low
- dump_req  in  1  single-cycle start pulse
- dump_busy  out  1  high from the cycle after an accepted dump_req until DONE
- dump_done  out  1  one-cycle pulse at end of sweep
- hold_alf  out  1  stall to the read stage, ORed into its input almost-full
- pipe_idle  in  1  read/compare stages have no entry in flight
- p_rden, p_rdaddr  in  1, ADDR_W  pipeline read request
- p_wren, p_wraddr, p_wrdata  in  1, ADDR_W, DATA_W  pipeline write request
- p_rdvalue  out  DATA_W  ram_q passed through to the compare stage
- ram_rden, ram_rdaddr, ram_wren, ram_wraddr, ram_wrdata  out  RAM port drive
- ram_q  in  DATA_W  RAM read data
- dump_wr  out  1  dump word valid
- dump_data  out  ADDR_W+DATA_W  {bucket address, bucket contents}
- dump_alf  in  1  collector almost full; pauses read issue
- conflict_err  out  1  sticky; a pipeline access arrived during SWEEP/FLUSH

## Operation
FSM states are IDLE, DRAIN, SWEEP, FLUSH and DONE.

- **IDLE:** RAM ports are a combinational mux of the pipeline ports; hold_alf=0. On dump_req, go to DRAIN.
- **DRAIN:** hold_alf=1; pipeline accesses are still forwarded. An idle counter increments while pipe_idle=1 and clears to 0 when pipe_idle=0. When the counter reaches DRAIN_MIN, go to SWEEP with sweep address = 0.
- **SWEEP:** the RAM mux selects the controller; the pipeline is not forwarded.
  - Each cycle with dump_alf=0: ram_rden=1, ram_rdaddr=sweep address, then increment the sweep address.
  - Each cycle with dump_alf=1: no read is issued and the address holds.
  - Issued addresses also enter an RD_LAT-deep valid/address shift pipe.
  - After address DEPTH-1 is issued, go to FLUSH. The address is wider than ADDR_W internally, so it does not wrap to 0.
- **Pipe output (SWEEP and FLUSH):** when the pipe's output stage is valid, with its address A:
  - ram_wren=1, ram_wraddr=A, ram_wrdata=0.
  - dump_wr=1 and dump_data={A, ram_q}, unless SKIP_EMPTY=1 and ram_q==0.
- **FLUSH:** no new reads. When the shift pipe is empty, go to DONE.
- **DONE:** dump_done=1 for one cycle, dump_busy=0 and hold_alf=0 in that same cycle; return to IDLE on the next cycle.
- **Collision rule:** sweep reads and writes never target the same address in the same cycle, because the write trails the read by RD_LAT.
- **dump_req outside IDLE** (including the DONE cycle) is ignored.
- **Pipeline access in SWEEP/FLUSH:** any p_rden or p_wren is dropped and sets conflict_err. conflict_err clears only on reset.
- **Reset:** asserting reset mid-operation forces IDLE, clears all counters and the shift pipe, and zeros all outputs. RAM contents are left partially cleared. Software re-issues dump_req.

## Timing
- Reset values: dump_busy, dump_done, hold_alf, dump_wr, conflict_err, ram_rden, ram_wren = 0; all address and data outputs = 0.
- IDLE passthrough has zero added latency; p_rdvalue = ram_q.
- Accepting dump_req at cycle t:
  - hold_alf and dump_busy go high at t+1.
  - The first sweep read is at the earliest cycle after DRAIN_MIN consecutive pipe_idle cycles observed in DRAIN.
- With no dump_alf stalls:
  - Reads are issued on DEPTH consecutive cycles.
  - The last dump_wr follows the last read by RD_LAT cycles.
  - dump_done follows the last dump_wr by 1 cycle.
- dump_alf is sampled in the same cycle as read issue. Reads already in the shift pipe still emit, so the collector must absorb RD_LAT words after it asserts alf.
- Sweep address arithmetic is unsigned ADDR_W+1 bits; SWEEP→FLUSH happens when the address reaches DEPTH.

## Test plan
- **Passthrough:** in IDLE, p_wren@addr 0x005 data 0xABC, then p_rden@0x005 → ram ports mirror the inputs in the same cycle; p_rdvalue=0xABC RD_LAT cycles after the read.
- **Full sweep, SKIP_EMPTY=1:**
  - Stimulus: preload buckets 0x000=1, 0x7FF=2, 0xFFF=3; pipe_idle=1; pulse dump_req.
  - Required: exactly 3 dump_wr words, {0x000,1}, {0x7FF,2}, {0xFFF,3}, in order.
  - Required: dump_done 1+DRAIN_MIN+4096+RD_LAT+1 cycles after the req (±1 per the chosen registering, fixed in the bench); a post-sweep read of all addresses returns 0.
- **Drain gating:** pipe_idle pattern 1,1,1,0,1,1,1,1 after the req → first sweep read follows the 4th consecutive 1; no read occurs before it.
- **Backpressure:** hold dump_alf=1 for 100 cycles mid-sweep → no skipped or duplicated addresses; total words equals the number of nonzero buckets.
- **Conflict and ignored request:** p_wren during SWEEP → not forwarded, conflict_err=1 persists after DONE; dump_req during SWEEP → no second sweep.
- **Reset mid-sweep:** reset low at sweep address 0x100 → all outputs 0 asynchronously; after release, FSM is in IDLE, a new dump_req sweeps from 0x000.
